fpu_wb_stage: RTL and testbench

Registered writeback stage directly downstream of the combinational `fpu`. It accepts each FPU result with its opcode and destination register, then post-processes it:
- NaN-boxes single-precision FP results.
- Sign-extends 32-bit integer results.
- Routes each result to the integer or FP register file.

Results are buffered in a small FIFO behind a valid/ready handshake. The block also exposes a pending-destination lookup so the issue logic can stall on hazards.

---
 rtl/fpu_pkg.sv | 39 +++
 rtl/fpu_wb_fifo.sv | 77 +++++++
 rtl/fpu_wb_stage.sv | 110 +++++++++++
 tb/tb_fpu_wb_stage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU opcode definitions, canonical NaNs and opcode classification helpers.
// Latency: n/a (package of constants and pure functions).
// Backpressure: n/a.
package fpu_pkg;

  // Opcode landmarks used by the classifiers below (same encoding as fpu_op)
  localparam logic [5:0] FOP_GAP_FIRST  = 6'h0A;  // first undefined op in the low gap
  localparam logic [5:0] FOP_GAP_LAST   = 6'h0F;  // last undefined op in the low gap
  localparam logic [5:0] FOP_CMP_FIRST  = 6'h14;  // feq/flt/fle group start
  localparam logic [5:0] FOP_CMP_LAST   = 6'h19;  // feq/flt/fle group end
  localparam logic [5:0] FOP_FMV_X      = 6'h20;  // move FP bits to integer file
  localparam logic [5:0] FOP_FCVT_L     = 6'h22;  // convert to 64-bit integer
  localparam logic [5:0] FOP_FCVT_S     = 6'h24;  // single-precision result
  localparam logic [5:0] FOP_FCVT_W_S   = 6'h26;  // single to 32-bit integer
  localparam logic [5:0] FOP_LAST       = 6'h27;  // highest defined op

  localparam logic [63:0] CNAN64 = 64'h7FF8000000000000;
  localparam logic [31:0] CNAN32 = 32'h7FC00000;

  function automatic logic fop_is_legal(input logic [5:0] op);
    return !(op >= FOP_GAP_FIRST && op <= FOP_GAP_LAST) && (op <= FOP_LAST);
  endfunction

  function automatic logic fop_dest_int(input logic [5:0] op);
    return (op >= FOP_CMP_FIRST && op <= FOP_CMP_LAST) ||
           (op == FOP_FMV_X) || (op == FOP_FCVT_L) || (op == FOP_FCVT_W_S);
  endfunction

  function automatic logic fop_is_single(input logic [5:0] op);
    return (op[0] && op >= 6'h01 && op <= 6'h09) ||
           (op inside {6'h11, 6'h13, 6'h1B, 6'h1D, 6'h1F, FOP_FCVT_S, FOP_LAST});
  endfunction

  // 32-bit integer results that must be sign-extended onto a 64-bit bus
  function automatic logic fop_is_sext(input logic [5:0] op);
    return op inside {6'h15, 6'h17, 6'h19, FOP_FCVT_W_S};
  endfunction

endpackage

// File: rtl/fpu_wb_fifo.sv
// Generic DEPTH x W synchronous FIFO with occupancy count and per-entry valid bits.
// Latency: a write at edge N is readable at the head in cycle N+1.
// Backpressure: writes are dropped when full (not_full=0); not_full depends on state only.
module fpu_wb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_vld,
  input  logic [W-1:0]               wr_dat,
  output logic                       not_full,
  output logic                       rd_vld,
  input  logic                       rd_rdy,
  output logic [W-1:0]               rd_dat,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [DEPTH-1:0]           ent_vld,
  output logic [DEPTH-1:0][W-1:0]    ent_dat
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]        vld_q, vld_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    do_push, do_pop;

  assign not_full = (count_q < CW'(DEPTH));
  assign rd_vld   = vld_q[rd_ptr_q];
  assign rd_dat   = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign ent_vld  = vld_q;
  assign ent_dat  = mem_q;

  // Next-state: pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    mem_d    = mem_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = wr_vld && not_full;
    do_pop   = rd_rdy && rd_vld;
    if (do_pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PW'(1);
    end
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_dat;
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  // State registers; storage is cleared so the head reads zero out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fpu_wb_stage.sv
// FPU writeback: NaN-box / sign-extend / route results, buffer them, answer hazard lookups.
// Latency: accepted at edge N, presented on out_valid in cycle N+1.
// Backpressure: in_ready = occupancy < DEPTH, registered state only; out_ready never reaches in_ready.
module fpu_wb_stage
  import fpu_pkg::*;
#(
  parameter int BUS_WIDTH = 64,
  parameter int OP_LEN    = 6,
  parameter int REG_ADDR  = 5,
  parameter int DEPTH     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BUS_WIDTH-1:0]       in_result,
  input  logic [OP_LEN-1:0]          in_op,
  input  logic [REG_ADDR-1:0]        in_rd,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BUS_WIDTH-1:0]       out_data,
  output logic [REG_ADDR-1:0]        out_rd,
  output logic                       out_to_int,
  output logic                       out_to_fp,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic [REG_ADDR-1:0]        query_rd,
  input  logic                       query_fp,
  output logic                       query_hit
);

  // Entry layout: {illegal, to_fp, to_int, rd, data}
  localparam int W      = BUS_WIDTH + REG_ADDR + 3;
  localparam int B_INT  = BUS_WIDTH + REG_ADDR;
  localparam int B_FP   = B_INT + 1;
  localparam int B_ILL  = B_INT + 2;

  logic [5:0]                 op6;
  logic                       op_hi_set;
  logic                       legal, to_int, single, sext, suppress;
  logic [BUS_WIDTH-1:0]       proc_data;
  logic [W-1:0]               head;
  logic [DEPTH-1:0]           ent_vld;
  logic [DEPTH-1:0][W-1:0]    ent_dat;

  assign op6 = 6'(in_op);

  if (OP_LEN > 6) begin : g_op_wide
    assign op_hi_set = |in_op[OP_LEN-1:6];
  end else begin : g_op_narrow
    assign op_hi_set = 1'b0;
  end

  // Classify the incoming op; x0 integer writes are swallowed at the handshake
  always_comb begin
    legal    = fop_is_legal(op6) && !op_hi_set;
    to_int   = legal && fop_dest_int(op6);
    single   = legal && fop_is_single(op6);
    sext     = legal && fop_is_sext(op6);
    suppress = to_int && (in_rd == '0);
  end

  if (BUS_WIDTH == 64) begin : g_w64
    // Format the 64-bit result: canonical NaN, NaN-box or sign-extend
    always_comb begin
      proc_data = in_result;
      if (!legal)      proc_data = BUS_WIDTH'(CNAN64);
      else if (single) proc_data = {32'hFFFFFFFF, in_result[31:0]};
      else if (sext)   proc_data = {{32{in_result[31]}}, in_result[31:0]};
    end
  end else begin : g_w32
    // On a 32-bit bus only illegal ops alter the data
    always_comb begin
      proc_data = in_result;
      if (!legal) proc_data = BUS_WIDTH'(CNAN32);
    end
  end

  fpu_wb_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_vld   (in_valid && !suppress),
    .wr_dat   ({!legal, !to_int, to_int, in_rd, proc_data}),
    .not_full (in_ready),
    .rd_vld   (out_valid),
    .rd_rdy   (out_ready),
    .rd_dat   (head),
    .count    (count),
    .ent_vld  (ent_vld),
    .ent_dat  (ent_dat)
  );

  assign out_data    = head[BUS_WIDTH-1:0];
  assign out_rd      = head[BUS_WIDTH +: REG_ADDR];
  assign out_to_int  = out_valid && head[B_INT];
  assign out_to_fp   = out_valid && head[B_FP];
  assign out_illegal = out_valid && head[B_ILL];

  // Hazard lookup across every pending entry, matching index and register file
  always_comb begin
    query_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && (ent_dat[i][BUS_WIDTH +: REG_ADDR] == query_rd) &&
          (ent_dat[i][B_FP] == query_fp))
        query_hit = 1'b1;
    end
    if (!query_fp && (query_rd == '0)) query_hit = 1'b0;
  end

endmodule

// File: tb/tb_fpu_wb_stage.sv
module tb_fpu_wb_stage;

  typedef struct packed {
    logic [63:0] d;
    logic [4:0]  rd;
    logic        ti;
    logic        tf;
    logic        il;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_result = '0;
  logic [5:0]  in_op = '0;
  logic [4:0]  in_rd = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [4:0]  out_rd;
  logic        out_to_int, out_to_fp, out_illegal;
  logic [1:0]  count;
  logic [4:0]  query_rd = '0;
  logic        query_fp = 1'b0;
  logic        query_hit;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  fpu_wb_stage #(.BUS_WIDTH(64), .OP_LEN(6), .REG_ADDR(5), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_op(in_op), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_to_int(out_to_int), .out_to_fp(out_to_fp),
    .out_illegal(out_illegal), .count(count),
    .query_rd(query_rd), .query_fp(query_fp), .query_hit(query_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one result and hold it until accepted; optionally record the expected output
  task automatic issue(input logic [5:0] op, input logic [63:0] res, input logic [4:0] rd,
                       input logic push, input logic [63:0] ed,
                       input logic ti, input logic tf, input logic il);
    bit ok = 1'b0;
    in_valid  = 1'b1;
    in_op     = op;
    in_result = res;
    in_rd     = rd;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    if (push) sb.push_back('{d: ed, rd: rd, ti: ti, tf: tf, il: il});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (count == 2'd0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain_done", {63'd0, ok}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_in_ready"},  {63'd0, in_ready},  64'd1);
    chk({tag, "_count"},     {62'd0, count},     64'd0);
    chk({tag, "_query_hit"}, {63'd0, query_hit}, 64'd0);
    chk({tag, "_out_data"},  out_data,           64'd0);
    chk({tag, "_out_rd"},    {59'd0, out_rd},    64'd0);
    chk({tag, "_flags"}, {61'd0, out_to_int, out_to_fp, out_illegal}, 64'd0);
  endtask

  // Scoreboard monitor: every dequeue is matched against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", {59'd0, out_rd}, 64'hFFFF);
        end else begin
          e = sb.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_rd", {59'd0, out_rd}, {59'd0, e.rd});
          chk("out_flags", {61'd0, out_to_int, out_to_fp, out_illegal},
              {61'd0, e.ti, e.tf, e.il});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    query_rd = 5'd3;
    query_fp = 1'b1;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Single-precision NaN-box with one-cycle latency
    issue(6'h01, 64'h0000000040400000, 5'd3, 1'b1, 64'hFFFFFFFF40400000, 1'b0, 1'b1, 1'b0);
    chk("nanbox_latency", {63'd0, out_valid}, 64'd1);

    // Integer sign-extension
    issue(6'h26, 64'h00000000FFFFFFFE, 5'd7, 1'b1, 64'hFFFFFFFFFFFFFFFE, 1'b1, 1'b0, 1'b0);
    issue(6'h17, 64'h0000000000000001, 5'd8, 1'b1, 64'h0000000000000001, 1'b1, 1'b0, 1'b0);

    // x0 suppression: handshake completes, nothing is queued
    issue(6'h14, 64'h0000000000000001, 5'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    chk("x0_count", {62'd0, count}, 64'd0);
    chk("x0_in_ready", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("x0_no_valid", {63'd0, out_valid}, 64'd0);
      chk("empty_flags", {61'd0, out_to_int, out_to_fp, out_illegal}, 64'd0);
    end
    @(posedge clk);
    #1;

    // Backpressure: A and B fill the FIFO, C waits
    out_ready = 1'b0;
    issue(6'h00, 64'h3FF0000000000000, 5'd1, 1'b1, 64'h3FF0000000000000, 1'b0, 1'b1, 1'b0);
    issue(6'h10, 64'h0000000000001234, 5'd2, 1'b1, 64'h0000000000001234, 1'b0, 1'b1, 1'b0);
    in_valid  = 1'b1;
    in_op     = 6'h1B;
    in_result = 64'hDEADBEEF3F800000;
    in_rd     = 5'd4;
    @(negedge clk);
    chk("full_count", {62'd0, count}, 64'd2);
    chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    chk("c_held_count", {62'd0, count}, 64'd2);
    sb.push_back('{d: 64'hFFFFFFFF3F800000, rd: 5'd4, ti: 1'b0, tf: 1'b1, il: 1'b0});
    out_ready = 1'b1;
    @(negedge clk);
    chk("in_ready_before_deq", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    chk("in_ready_after_deq", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("simul_enq_deq_count", {62'd0, count}, 64'd1);
    drain();

    // Hazard lookup and illegal op
    out_ready = 1'b0;
    issue(6'h04, 64'h4000000000000000, 5'd5, 1'b1, 64'h4000000000000000, 1'b0, 1'b1, 1'b0);
    query_rd = 5'd5; query_fp = 1'b1; #1;
    chk("hit_fp5", {63'd0, query_hit}, 64'd1);
    query_fp = 1'b0; #1;
    chk("miss_int5", {63'd0, query_hit}, 64'd0);
    query_rd = 5'd6; query_fp = 1'b1; #1;
    chk("miss_fp6", {63'd0, query_hit}, 64'd0);
    issue(6'h0C, 64'h000000000000007B, 5'd9, 1'b1, 64'h7FF8000000000000, 1'b0, 1'b1, 1'b1);
    query_rd = 5'd9; query_fp = 1'b1; #1;
    chk("hit_illegal_fp9", {63'd0, query_hit}, 64'd1);
    query_rd = 5'd0; query_fp = 1'b0; #1;
    chk("miss_int0", {63'd0, query_hit}, 64'd0);
    out_ready = 1'b1;
    drain();

    // Reset mid-operation with two entries pending; they are discarded
    out_ready = 1'b0;
    issue(6'h02, 64'h0000000000000011, 5'd10, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    issue(6'h03, 64'h0000000000000022, 5'd11, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    chk("pre_reset_count", {62'd0, count}, 64'd2);
    query_rd = 5'd10; query_fp = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(6'h20, 64'hAAAABBBBCCCCDDDD, 5'd12, 1'b1, 64'hAAAABBBBCCCCDDDD, 1'b1, 1'b0, 1'b0);
    chk("post_reset_latency", {63'd0, out_valid}, 64'd1);
    drain();

    @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
